// File: rtl/accum_ctrl_pkg.sv
// Shared types and defaults for the accumulator run controller.
package accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_STEP  = 5;
  localparam int DEF_W     = 16;
  localparam int STEPS_W   = 14;
  localparam logic [STEPS_W-1:0] STEPS_MAX = '1;

endpackage

// File: rtl/accum_ctrl.sv
// Run controller for an external accumulator C <= C+STEP / C <= 0.
// Clears the accumulator, then enables it every cycle the next increment
// still fits under the latched target, and parks in DONE.
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int STEP = DEF_STEP,
  parameter int W    = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       target,
  input  logic [W-1:0]       C,
  output logic               Conen,
  output logic               Conclr,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps
);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_tgt;
  logic [STEPS_W-1:0] r_steps;

  logic [W:0]         w_sum;
  logic               w_fits;
  logic               w_accept;
  logic               w_clr_steps;

  // One extra bit so C+STEP near the top of the range cannot wrap.
  assign w_sum  = {1'b0, C} + (W+1)'(STEP);
  assign w_fits = (w_sum <= {1'b0, r_tgt});

  // A start is only heard while parked; abort always wins.
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;

  // Steps restart with the clear cycle unless that cycle is being aborted.
  assign w_clr_steps = (r_state == ST_CLEAR) && !abort;

  assign steps = r_steps;

  // Next-state and outputs; reset forces a clear pulse with everything else low.
  always_comb begin
    w_next = r_state;
    Conen  = 1'b0;
    Conclr = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    if (rst) begin
      Conclr = 1'b1;
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) w_next = ST_CLEAR;
        end
        ST_CLEAR: begin
          busy = 1'b1;
          if (abort) begin
            // Aborted runs leave C untouched.
            w_next = ST_IDLE;
          end else begin
            Conclr = 1'b1;
            w_next = ST_RUN;
          end
        end
        ST_RUN: begin
          busy = 1'b1;
          if (abort)       w_next = ST_IDLE;
          else if (w_fits) Conen  = 1'b1;
          else             w_next = ST_DONE;
        end
        ST_DONE: begin
          done = 1'b1;
          if (abort)         w_next = ST_IDLE;
          else if (w_accept) w_next = ST_CLEAR;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State, latched target and saturating enable-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_steps <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_tgt <= target;
      if (w_clr_steps)
        r_steps <= '0;
      else if (Conen && (r_steps != STEPS_MAX))
        r_steps <= r_steps + 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench: accum_ctrl driving a STEP=5 accumulator model.
module tb_accum_ctrl;

  localparam int STEP = 5;
  localparam int W    = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] target;
  logic [15:0] C;
  logic        Conen, Conclr, busy, done;
  logic [13:0] steps;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned c;
    int unsigned s;
    int unsigned t;
  } exp_t;
  exp_t sbq[$];

  accum_ctrl #(.STEP(STEP), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .C(C), .Conen(Conen), .Conclr(Conclr), .busy(busy), .done(done), .steps(steps)
  );

  always #5 clk = ~clk;

  // Downstream accumulator as integrated beside the controller.
  always_ff @(posedge clk) begin
    if (Conclr)     C <= '0;
    else if (Conen) C <= C + 16'(STEP);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a run ends on the largest multiple of STEP not above the target.
  function automatic exp_t ref_run(input int unsigned t);
    exp_t e;
    e.t = t;
    e.s = t / STEP;
    if (e.s > 16383) e.s = 16383;
    e.c = (t / STEP) * STEP;
    return e;
  endfunction

  // Monitor: compares each completed run against the queued expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    chk("conen_conclr_exclusive", longint'(Conen && Conclr), 0);
    if (done && !prev_done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got done with C=%0d, expected no completion", C);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("final_C_t%0d", e.t), C, e.c);
        chk($sformatf("steps_t%0d", e.t), steps, e.s);
        chk($sformatf("busy_at_done_t%0d", e.t), busy, 0);
      end
    end
    prev_done = done;
  end

  task automatic issue_start(input logic [15:0] t);
    @(posedge clk); #1;
    start  = 1'b1;
    target = t;
    @(posedge clk); #1;
    start  = 1'b0;
    target = 16'($urandom);
  endtask

  task automatic run_to_done(input int unsigned t);
    int n = 0;
    int cyc = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    target = 16'(t);
    @(posedge clk);
    sbq.push_back(ref_run(t));
    #1;
    start  = 1'b0;
    target = 16'($urandom);
    @(negedge clk);
    chk("clear_conclr", Conclr, 1);
    chk("clear_conen", Conen, 0);
    chk("clear_busy", busy, 1);
    @(negedge clk);
    chk("first_run_C0", C, 0);
    chk("first_run_steps0", steps, 0);
    for (int i = 0; i < 20000; i++) begin
      if (done) break;
      if (Conen) n++;
      cyc++;
      // Stray starts while busy must be ignored.
      start  = ($urandom_range(0, 3) == 0);
      target = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("done_reached_t%0d", t), done, 1);
    chk($sformatf("conen_pulses_t%0d", t), n, t / STEP);
    if (t < STEP) chk($sformatf("short_run_len_t%0d", t), cyc, 1);
    repeat (2) @(negedge clk);
    chk($sformatf("done_held_t%0d", t), done, 1);
    chk($sformatf("C_held_t%0d", t), C, (t / STEP) * STEP);
  endtask

  initial begin
    int n;
    bit pulsed;
    rst = 1'b1; start = 1'b0; abort = 1'b0; target = '0;

    // Reset behaviour.
    @(negedge clk);
    chk("rst_conclr", Conclr, 1);
    chk("rst_conen", Conen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_steps", steps, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_C", C, 0);
    chk("post_rst_conclr", Conclr, 0);

    // Directed runs, including boundaries.
    run_to_done(20);
    run_to_done(23);
    run_to_done(4);
    run_to_done(0);
    run_to_done(65535);
    run_to_done(10);
    run_to_done(7);

    // Abort after three enabled cycles, with an ignored start mid-run.
    issue_start(16'd100);
    n = 0;
    pulsed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (Conen) n++;
      if (n == 1 && !pulsed) begin
        start  = 1'b1;
        target = 16'd5;
        pulsed = 1'b1;
      end
      if (n == 3) break;
    end
    start = 1'b0;
    chk("abort_reached_3", n, 3);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_conen", Conen, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_C", C, 15);
    chk("abort_steps", steps, 3);
    repeat (3) @(negedge clk);
    chk("abort_C_held", C, 15);
    chk("abort_idle_conen", Conen, 0);

    // Reset in the middle of a run.
    issue_start(16'd100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (C == 16'd35) break;
    end
    chk("rst_mid_C35", C, 35);
    rst = 1'b1;
    #1;
    chk("rst_mid_conclr", Conclr, 1);
    chk("rst_mid_conen", Conen, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_C_after", C, 0);
    chk("rst_mid_steps", steps, 0);
    chk("rst_mid_busy_after", busy, 0);
    chk("rst_mid_done_after", done, 0);
    chk("rst_mid_conclr_after", Conclr, 0);
    n = 0;
    repeat (5) begin
      if (Conen) n++;
      @(negedge clk);
    end
    chk("rst_mid_no_conen", n, 0);

    // Randomized runs.
    for (int r = 0; r < 20; r++) run_to_done($urandom_range(0, 400));

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
